fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 63 ++++++
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: request channel to the instruction responder,
// return channel from it, issue channel to the next stage and status flags.
interface fetch_unit_if #(
   parameter int PC_BIT      = 8,
   parameter int INST_ID_BIT = 8,
   parameter int OP_BIT      = 3,
   parameter int TAG_ID_BIT  = 2,
   parameter int IMM_BIT     = 4
);
   logic                   fetch_vld;
   logic                   fetch_rdy;
   logic [PC_BIT-1:0]      fetch_pc;
   logic [INST_ID_BIT-1:0] fetch_id;

   logic                   inst_vld;
   logic                   inst_rdy;
   logic [INST_ID_BIT-1:0] inst_id;
   logic                   inst_last;
   logic [OP_BIT-1:0]      inst_op;
   logic [TAG_ID_BIT-1:0]  inst_dst_reg;
   logic [TAG_ID_BIT-1:0]  inst_src_reg0;
   logic [TAG_ID_BIT-1:0]  inst_src_reg1;
   logic [IMM_BIT-1:0]     inst_imm;

   logic                   issue_vld;
   logic                   issue_rdy;
   logic [INST_ID_BIT-1:0] issue_id;
   logic                   issue_last;
   logic [OP_BIT-1:0]      issue_op;
   logic [TAG_ID_BIT-1:0]  issue_dst_reg;
   logic [TAG_ID_BIT-1:0]  issue_src_reg0;
   logic [TAG_ID_BIT-1:0]  issue_src_reg1;
   logic [IMM_BIT-1:0]     issue_imm;

   logic                   id_error;
   logic                   fetch_done;

   // The fetch unit itself
   modport master (
      output fetch_vld, fetch_pc, fetch_id,
      input  fetch_rdy,
      input  inst_vld, inst_id, inst_last, inst_op, inst_dst_reg,
             inst_src_reg0, inst_src_reg1, inst_imm,
      output inst_rdy,
      output issue_vld, issue_id, issue_last, issue_op, issue_dst_reg,
             issue_src_reg0, issue_src_reg1, issue_imm,
      input  issue_rdy,
      output id_error, fetch_done
   );

   // The surrounding environment (responder plus issue stage)
   modport slave (
      input  fetch_vld, fetch_pc, fetch_id,
      output fetch_rdy,
      output inst_vld, inst_id, inst_last, inst_op, inst_dst_reg,
             inst_src_reg0, inst_src_reg1, inst_imm,
      input  inst_rdy,
      input  issue_vld, issue_id, issue_last, issue_op, issue_dst_reg,
             issue_src_reg0, issue_src_reg1, issue_imm,
      output issue_rdy,
      input  id_error, fetch_done
   );
endinterface

// File: rtl/fetch_unit.sv
// Credit-based in-order instruction fetch unit. Requests are only issued
// while the requests in flight plus the queued instructions leave room in
// the queue, so every return can always be accepted. After the instruction
// flagged last is returned, the unit stops requesting, discards the
// over-fetched returns and reports done once everything has drained.
module fetch_unit #(
   parameter int PC_BIT      = 8,
   parameter int INST_ID_BIT = 8,
   parameter int OP_BIT      = 3,
   parameter int TAG_ID_BIT  = 2,
   parameter int IMM_BIT     = 4,
   parameter int QUEUE_SIZE  = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);
   localparam int PTR_W = $clog2(QUEUE_SIZE);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] QSIZE      = CNT_W'(QUEUE_SIZE);
   localparam logic [CNT_W:0]   QSIZE_WIDE = (CNT_W+1)'(QUEUE_SIZE);

   typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic [INST_ID_BIT-1:0] id;
      logic                   last;
      logic [OP_BIT-1:0]      op;
      logic [TAG_ID_BIT-1:0]  dst;
      logic [TAG_ID_BIT-1:0]  src0;
      logic [TAG_ID_BIT-1:0]  src1;
      logic [IMM_BIT-1:0]     imm;
   } entry_t;

   state_t                 r_state;
   state_t                 w_nextState;
   logic [PC_BIT-1:0]      r_pc;
   logic [INST_ID_BIT-1:0] r_fetchId;
   logic [INST_ID_BIT-1:0] r_expId;
   logic [CNT_W-1:0]       r_outstanding;
   logic [CNT_W-1:0]       r_count;
   logic [PTR_W-1:0]       r_head;
   logic [PTR_W-1:0]       r_tail;
   logic                   r_idError;
   entry_t                 r_mem [QUEUE_SIZE];

   logic [CNT_W:0]         w_inFlight;
   logic                   w_credit;
   logic                   w_fetchVld;
   logic                   w_instRdy;
   logic                   w_issueVld;
   logic                   w_fetchHs;
   logic                   w_retHs;
   logic                   w_issueHs;
   logic                   w_push;
   entry_t                 w_newEntry;
   entry_t                 w_headEntry;

   // Outputs are forced quiet while reset is held, whatever the registers say
   assign w_inFlight = {1'b0, r_outstanding} + {1'b0, r_count};
   assign w_credit   = (w_inFlight < QSIZE_WIDE);
   assign w_instRdy  = rst_n && (r_count < QSIZE);
   assign w_issueVld = (r_count != '0);
   assign w_fetchHs  = w_fetchVld && bus.fetch_rdy;
   assign w_retHs    = bus.inst_vld && w_instRdy;
   assign w_issueHs  = w_issueVld && bus.issue_rdy;

   assign w_newEntry = '{id:   bus.inst_id,       last: bus.inst_last,
                         op:   bus.inst_op,       dst:  bus.inst_dst_reg,
                         src0: bus.inst_src_reg0, src1: bus.inst_src_reg1,
                         imm:  bus.inst_imm};
   assign w_headEntry = r_mem[r_head];

   assign bus.fetch_vld      = w_fetchVld;
   assign bus.fetch_pc       = r_pc;
   assign bus.fetch_id       = r_fetchId;
   assign bus.inst_rdy       = w_instRdy;
   assign bus.issue_vld      = w_issueVld;
   assign bus.issue_id       = w_headEntry.id;
   assign bus.issue_last     = w_headEntry.last;
   assign bus.issue_op       = w_headEntry.op;
   assign bus.issue_dst_reg  = w_headEntry.dst;
   assign bus.issue_src_reg0 = w_headEntry.src0;
   assign bus.issue_src_reg1 = w_headEntry.src1;
   assign bus.issue_imm      = w_headEntry.imm;
   assign bus.id_error       = r_idError;
   assign bus.fetch_done     = (r_state == S_DONE);

   // Next state, request enable and whether a return is kept or dropped
   always_comb begin
      w_nextState = r_state;
      w_fetchVld  = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_fetchVld = rst_n && w_credit;
            w_push     = w_retHs;
            if (w_retHs && bus.inst_last) begin
               w_nextState = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((r_count == '0) && (r_outstanding == '0)) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE:  w_nextState = S_DONE;
         default: w_nextState = S_FETCH;
      endcase
   end

   // State register, request counters, ID tracking and queue pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_FETCH;
         r_pc          <= '0;
         r_fetchId     <= '0;
         r_expId       <= '0;
         r_outstanding <= '0;
         r_count       <= '0;
         r_head        <= '0;
         r_tail        <= '0;
         r_idError     <= 1'b0;
      end else begin
         r_state       <= w_nextState;
         r_outstanding <= r_outstanding + CNT_W'(w_fetchHs) - CNT_W'(w_retHs);
         r_count       <= r_count + CNT_W'(w_push) - CNT_W'(w_issueHs);
         if (w_fetchHs) begin
            r_pc      <= r_pc + PC_BIT'(1);
            r_fetchId <= r_fetchId + INST_ID_BIT'(1);
         end
         if (w_retHs) begin
            r_expId <= r_expId + INST_ID_BIT'(1);
            if (bus.inst_id != r_expId) begin
               r_idError <= 1'b1;
            end
         end
         if (w_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_issueHs) begin
            r_head <= r_head + PTR_W'(1);
         end
      end
   end

   // Queue storage needs no reset; validity is tracked by the count
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_tail] <= w_newEntry;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a randomized responder and issue stage drive the
// unit once per cycle, and each scenario compares what it saw against a
// program-level expectation (PC n fetched n-th, issued as instruction n).
module tb_fetch_unit;
   localparam int PC_BIT      = 8;
   localparam int INST_ID_BIT = 8;
   localparam int OP_BIT      = 3;
   localparam int TAG_ID_BIT  = 2;
   localparam int IMM_BIT     = 4;
   localparam int QUEUE_SIZE  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   fetch_unit_if #(.PC_BIT(PC_BIT), .INST_ID_BIT(INST_ID_BIT), .OP_BIT(OP_BIT),
                   .TAG_ID_BIT(TAG_ID_BIT), .IMM_BIT(IMM_BIT)) bus ();

   fetch_unit #(.PC_BIT(PC_BIT), .INST_ID_BIT(INST_ID_BIT), .OP_BIT(OP_BIT),
                .TAG_ID_BIT(TAG_ID_BIT), .IMM_BIT(IMM_BIT),
                .QUEUE_SIZE(QUEUE_SIZE)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      int         pc;
      logic [7:0] id;
      int         readyCycle;
   } req_t;

   int checks = 0;
   int failures = 0;

   logic [2:0] progOp   [256];
   logic [1:0] progDst  [256];
   logic [1:0] progSrc0 [256];
   logic [1:0] progSrc1 [256];
   logic [3:0] progImm  [256];

   int lastPc, respLat, fetchRdyPct, instVldPct, issueRdyPct, corruptRet;
   req_t respQ[$];
   int obsFetchPc[$];
   int obsFetchId[$];
   logic [21:0] obsIssue[$];
   int tbOut, tbQ, maxCredit, fetchAfterLast, retCount, cycle;
   bit lastSeen, doneSeen;

   // Expected issue word for program slot pc carrying a given id
   function automatic logic [21:0] progEntry(int pc, logic [7:0] id, logic last);
      return {id, last, progOp[pc], progDst[pc], progSrc0[pc], progSrc1[pc], progImm[pc]};
   endfunction

   // Issue head as currently presented by the DUT
   function automatic logic [21:0] issueWord();
      return {bus.issue_id, bus.issue_last, bus.issue_op, bus.issue_dst_reg,
              bus.issue_src_reg0, bus.issue_src_reg1, bus.issue_imm};
   endfunction

   task automatic loadProgram();
      for (int i = 0; i < 256; i++) begin
         progOp[i]   = 3'($urandom);
         progDst[i]  = 2'($urandom);
         progSrc0[i] = 2'($urandom);
         progSrc1[i] = 2'($urandom);
         progImm[i]  = 4'($urandom);
      end
   endtask

   task automatic driveIdle();
      bus.fetch_rdy     = 1'b0;
      bus.inst_vld      = 1'b0;
      bus.inst_id       = '0;
      bus.inst_last     = 1'b0;
      bus.inst_op       = '0;
      bus.inst_dst_reg  = '0;
      bus.inst_src_reg0 = '0;
      bus.inst_src_reg1 = '0;
      bus.inst_imm      = '0;
      bus.issue_rdy     = 1'b0;
   endtask

   task automatic clearModel();
      respQ.delete();
      obsFetchPc.delete();
      obsFetchId.delete();
      obsIssue.delete();
      tbOut = 0; tbQ = 0; maxCredit = 0; fetchAfterLast = 0;
      retCount = 0; cycle = 0; lastSeen = 0; doneSeen = 0;
      corruptRet = -1;
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst_n = 1'b0;
      driveIdle();
      repeat (2) @(negedge clk);
      clearModel();
      loadProgram();
      rst_n = 1'b1;
   endtask

   // One cycle of responder / issue-stage behaviour plus bookkeeping
   task automatic applyStimulus();
      bit fHs, rHs, iHs;
      logic [7:0] retId;
      logic retLast;
      int retPc;
      retLast = 1'b0;
      retPc = 0;
      @(negedge clk);
      bus.fetch_rdy = ($urandom_range(99) < fetchRdyPct);
      bus.issue_rdy = ($urandom_range(99) < issueRdyPct);
      bus.inst_vld  = 1'b0;
      if (respQ.size() > 0 && respQ[0].readyCycle <= cycle &&
          $urandom_range(99) < instVldPct) begin
         retPc   = respQ[0].pc;
         retId   = respQ[0].id;
         if (retCount == corruptRet) retId = retId + 8'd1;
         retLast = (retPc == lastPc);
         bus.inst_vld      = 1'b1;
         bus.inst_id       = retId;
         bus.inst_last     = retLast;
         bus.inst_op       = progOp[retPc];
         bus.inst_dst_reg  = progDst[retPc];
         bus.inst_src_reg0 = progSrc0[retPc];
         bus.inst_src_reg1 = progSrc1[retPc];
         bus.inst_imm      = progImm[retPc];
      end
      #1;
      fHs = bus.fetch_vld && bus.fetch_rdy;
      rHs = bus.inst_vld && bus.inst_rdy;
      iHs = bus.issue_vld && bus.issue_rdy;
      if (fHs && lastSeen) fetchAfterLast++;
      if (rHs) begin
         void'(respQ.pop_front());
         retCount++;
         tbOut--;
         if (!lastSeen) begin
            tbQ++;
            if (retLast) lastSeen = 1;
         end
      end
      if (fHs) begin
         obsFetchPc.push_back(int'(bus.fetch_pc));
         obsFetchId.push_back(int'(bus.fetch_id));
         respQ.push_back('{pc: int'(bus.fetch_pc), id: bus.fetch_id,
                           readyCycle: cycle + respLat});
         tbOut++;
      end
      if (iHs) begin
         obsIssue.push_back(issueWord());
         tbQ--;
      end
      if (tbOut + tbQ > maxCredit) maxCredit = tbOut + tbQ;
      if (bus.fetch_done) doneSeen = 1;
      cycle++;
   endtask

   task automatic runUntilDone(int budget);
      int n = 0;
      while (!doneSeen && n < budget) begin
         applyStimulus();
         n++;
      end
   endtask

   task automatic setRates(int f, int v, int s, int lat);
      fetchRdyPct = f; instVldPct = v; issueRdyPct = s; respLat = lat;
   endtask

   task automatic test_reset();
      #3;
      rst_n = 1'b0;
      driveIdle();
      #1;
      checks++; if (bus.fetch_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_fetch_vld: got %b expected 0", bus.fetch_vld); end
      checks++; if (bus.inst_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_inst_rdy: got %b expected 0", bus.inst_rdy); end
      checks++; if (bus.issue_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_issue_vld: got %b expected 0", bus.issue_vld); end
      checks++; if (bus.fetch_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_fetch_done: got %b expected 0", bus.fetch_done); end
      checks++; if (bus.id_error !== 1'b0) begin failures++; $display("[TB] FAIL reset_id_error: got %b expected 0", bus.id_error); end
      repeat (2) @(negedge clk);
      clearModel();
      loadProgram();
      setRates(0, 100, 100, 1);
      lastPc = 200;
      rst_n = 1'b1;
      applyStimulus();
      checks++; if (bus.fetch_vld !== 1'b1) begin failures++; $display("[TB] FAIL release_fetch_vld: got %b expected 1", bus.fetch_vld); end
      checks++; if (bus.fetch_pc !== 8'd0) begin failures++; $display("[TB] FAIL release_fetch_pc: got %0d expected 0", bus.fetch_pc); end
      checks++; if (bus.fetch_id !== 8'd0) begin failures++; $display("[TB] FAIL release_fetch_id: got %0d expected 0", bus.fetch_id); end
   endtask

   task automatic test_full_program();
      resetDut();
      setRates(100, 100, 100, 1);
      lastPc = 31;
      runUntilDone(500);
      checks++; if (!doneSeen) begin failures++; $display("[TB] FAIL full_done_timeout: got 0 expected fetch_done within 500 cycles"); end
      checks++; if (obsIssue.size() != 32) begin failures++; $display("[TB] FAIL full_issue_count: got %0d expected 32", obsIssue.size()); end
      for (int i = 0; i < obsIssue.size() && i < 32; i++) begin
         checks++;
         if (obsIssue[i] !== progEntry(i, 8'(i), i == 31)) begin failures++; $display("[TB] FAIL full_issue[%0d]: got %h expected %h", i, obsIssue[i], progEntry(i, 8'(i), i == 31)); end
      end
      for (int i = 0; i < obsFetchPc.size(); i++) begin
         checks++;
         if (obsFetchPc[i] != i || obsFetchId[i] != i) begin failures++; $display("[TB] FAIL full_fetch_seq[%0d]: got pc %0d id %0d expected %0d", i, obsFetchPc[i], obsFetchId[i], i); end
      end
      checks++; if (fetchAfterLast != 0) begin failures++; $display("[TB] FAIL full_fetch_after_last: got %0d expected 0", fetchAfterLast); end
      checks++; if (maxCredit > QUEUE_SIZE) begin failures++; $display("[TB] FAIL full_credit: got %0d expected <= %0d", maxCredit, QUEUE_SIZE); end
      checks++; if (bus.fetch_vld !== 1'b0 || bus.fetch_done !== 1'b1) begin failures++; $display("[TB] FAIL full_final: got vld %b done %b expected vld 0 done 1", bus.fetch_vld, bus.fetch_done); end
      checks++; if (bus.id_error !== 1'b0) begin failures++; $display("[TB] FAIL full_id_error: got %b expected 0", bus.id_error); end
   endtask

   task automatic test_backpressure();
      resetDut();
      setRates(100, 100, 0, 1);
      lastPc = 200;
      repeat (30) applyStimulus();
      checks++; if (obsFetchPc.size() != QUEUE_SIZE) begin failures++; $display("[TB] FAIL bp_fetch_count: got %0d expected %0d", obsFetchPc.size(), QUEUE_SIZE); end
      checks++; if (bus.fetch_vld !== 1'b0) begin failures++; $display("[TB] FAIL bp_fetch_vld: got %b expected 0", bus.fetch_vld); end
      checks++; if (bus.inst_rdy !== 1'b0) begin failures++; $display("[TB] FAIL bp_inst_rdy: got %b expected 0", bus.inst_rdy); end
      checks++; if (bus.issue_vld !== 1'b1) begin failures++; $display("[TB] FAIL bp_issue_vld: got %b expected 1", bus.issue_vld); end
      checks++; if (tbQ != QUEUE_SIZE) begin failures++; $display("[TB] FAIL bp_queued: got %0d expected %0d", tbQ, QUEUE_SIZE); end
      checks++; if (issueWord() !== progEntry(0, 8'd0, 1'b0)) begin failures++; $display("[TB] FAIL bp_head: got %h expected %h", issueWord(), progEntry(0, 8'd0, 1'b0)); end
      issueRdyPct = 100;
      repeat (40) applyStimulus();
      checks++; if (obsIssue.size() < 20) begin failures++; $display("[TB] FAIL bp_resume_count: got %0d expected >= 20", obsIssue.size()); end
      for (int i = 0; i < obsIssue.size(); i++) begin
         checks++;
         if (obsIssue[i] !== progEntry(i, 8'(i), 1'b0)) begin failures++; $display("[TB] FAIL bp_issue[%0d]: got %h expected %h", i, obsIssue[i], progEntry(i, 8'(i), 1'b0)); end
      end
      checks++; if (maxCredit > QUEUE_SIZE) begin failures++; $display("[TB] FAIL bp_credit: got %0d expected <= %0d", maxCredit, QUEUE_SIZE); end
   endtask

   task automatic test_fetch_stall();
      int expPc;
      resetDut();
      setRates(100, 100, 100, 1);
      lastPc = 200;
      repeat (3) applyStimulus();
      fetchRdyPct = 0;
      expPc = obsFetchPc.size();
      for (int k = 0; k < 5; k++) begin
         applyStimulus();
         checks++;
         if (bus.fetch_vld !== 1'b1 || bus.fetch_pc !== 8'(expPc) || bus.fetch_id !== 8'(expPc)) begin
            failures++; $display("[TB] FAIL stall_hold[%0d]: got vld %b pc %0d id %0d expected vld 1 pc/id %0d", k, bus.fetch_vld, bus.fetch_pc, bus.fetch_id, expPc);
         end
      end
      fetchRdyPct = 100;
      applyStimulus();
      checks++; if (obsFetchPc.size() != expPc + 1 || obsFetchPc[obsFetchPc.size()-1] != expPc) begin failures++; $display("[TB] FAIL stall_accept: got %0d fetches expected %0d ending at pc %0d", obsFetchPc.size(), expPc + 1, expPc); end
      applyStimulus();
      checks++; if (bus.fetch_pc !== 8'(expPc + 1)) begin failures++; $display("[TB] FAIL stall_advance: got %0d expected %0d", bus.fetch_pc, expPc + 1); end
   endtask

   task automatic test_id_error();
      int n = 0;
      resetDut();
      setRates(100, 100, 100, 1);
      lastPc = 12;
      corruptRet = 2;
      while (retCount < 3 && n < 50) begin
         applyStimulus();
         n++;
      end
      checks++; if (retCount != 3) begin failures++; $display("[TB] FAIL iderr_timeout: got %0d returns expected 3", retCount); end
      checks++; if (bus.id_error !== 1'b0) begin failures++; $display("[TB] FAIL iderr_before: got %b expected 0", bus.id_error); end
      applyStimulus();
      checks++; if (bus.id_error !== 1'b1) begin failures++; $display("[TB] FAIL iderr_set: got %b expected 1", bus.id_error); end
      runUntilDone(300);
      checks++; if (!doneSeen) begin failures++; $display("[TB] FAIL iderr_done_timeout: got 0 expected fetch_done within 300 cycles"); end
      checks++; if (bus.id_error !== 1'b1) begin failures++; $display("[TB] FAIL iderr_sticky: got %b expected 1", bus.id_error); end
      checks++; if (obsIssue.size() != 13) begin failures++; $display("[TB] FAIL iderr_issue_count: got %0d expected 13", obsIssue.size()); end
      for (int i = 0; i < obsIssue.size() && i < 13; i++) begin
         checks++;
         if (obsIssue[i] !== progEntry(i, (i == 2) ? 8'd3 : 8'(i), i == 12)) begin failures++; $display("[TB] FAIL iderr_issue[%0d]: got %h expected %h", i, obsIssue[i], progEntry(i, (i == 2) ? 8'd3 : 8'(i), i == 12)); end
      end
      resetDut();
      checks++; if (bus.id_error !== 1'b0) begin failures++; $display("[TB] FAIL iderr_cleared: got %b expected 0", bus.id_error); end
   endtask

   task automatic test_early_last();
      int fetched;
      resetDut();
      setRates(100, 100, 100, 3);
      lastPc = 5;
      runUntilDone(300);
      checks++; if (!doneSeen) begin failures++; $display("[TB] FAIL early_done_timeout: got 0 expected fetch_done within 300 cycles"); end
      checks++; if (obsIssue.size() != 6) begin failures++; $display("[TB] FAIL early_issue_count: got %0d expected 6", obsIssue.size()); end
      for (int i = 0; i < obsIssue.size() && i < 6; i++) begin
         checks++;
         if (obsIssue[i] !== progEntry(i, 8'(i), i == 5)) begin failures++; $display("[TB] FAIL early_issue[%0d]: got %h expected %h", i, obsIssue[i], progEntry(i, 8'(i), i == 5)); end
      end
      checks++; if (obsFetchPc.size() <= 6) begin failures++; $display("[TB] FAIL early_overfetch: got %0d fetches expected more than 6", obsFetchPc.size()); end
      checks++; if (retCount != obsFetchPc.size()) begin failures++; $display("[TB] FAIL early_all_returned: got %0d returns expected %0d", retCount, obsFetchPc.size()); end
      checks++; if (fetchAfterLast != 0) begin failures++; $display("[TB] FAIL early_fetch_after_last: got %0d expected 0", fetchAfterLast); end
      fetched = obsFetchPc.size();
      repeat (5) applyStimulus();
      checks++; if (bus.fetch_done !== 1'b1 || bus.fetch_vld !== 1'b0 || obsFetchPc.size() != fetched) begin failures++; $display("[TB] FAIL early_hold_done: got done %b vld %b fetches %0d expected done 1 vld 0 fetches %0d", bus.fetch_done, bus.fetch_vld, obsFetchPc.size(), fetched); end
   endtask

   task automatic test_reset_midway();
      resetDut();
      setRates(70, 70, 70, 2);
      lastPc = 100;
      repeat (25) applyStimulus();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.fetch_vld !== 1'b0 || bus.inst_rdy !== 1'b0 || bus.issue_vld !== 1'b0 || bus.fetch_done !== 1'b0) begin
         failures++; $display("[TB] FAIL midreset_outputs: got vld %b rdy %b ivld %b done %b expected all 0", bus.fetch_vld, bus.inst_rdy, bus.issue_vld, bus.fetch_done);
      end
      driveIdle();
      repeat (2) @(negedge clk);
      clearModel();
      setRates(100, 100, 100, 1);
      rst_n = 1'b1;
      repeat (15) applyStimulus();
      checks++; if (obsFetchPc.size() < 8) begin failures++; $display("[TB] FAIL midreset_fetch_count: got %0d expected >= 8", obsFetchPc.size()); end
      for (int i = 0; i < obsFetchPc.size(); i++) begin
         checks++;
         if (obsFetchPc[i] != i || obsFetchId[i] != i) begin failures++; $display("[TB] FAIL midreset_fetch[%0d]: got pc %0d id %0d expected %0d", i, obsFetchPc[i], obsFetchId[i], i); end
      end
      for (int i = 0; i < obsIssue.size(); i++) begin
         checks++;
         if (obsIssue[i] !== progEntry(i, 8'(i), 1'b0)) begin failures++; $display("[TB] FAIL midreset_issue[%0d]: got %h expected %h", i, obsIssue[i], progEntry(i, 8'(i), 1'b0)); end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         resetDut();
         setRates($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(4, 1));
         lastPc = $urandom_range(60, 10);
         runUntilDone(4000);
         checks++; if (!doneSeen) begin failures++; $display("[TB] FAIL rand%0d_done_timeout: got 0 expected fetch_done within 4000 cycles", r); end
         checks++; if (obsIssue.size() != lastPc + 1) begin failures++; $display("[TB] FAIL rand%0d_issue_count: got %0d expected %0d", r, obsIssue.size(), lastPc + 1); end
         for (int i = 0; i < obsIssue.size() && i <= lastPc; i++) begin
            checks++;
            if (obsIssue[i] !== progEntry(i, 8'(i), i == lastPc)) begin failures++; $display("[TB] FAIL rand%0d_issue[%0d]: got %h expected %h", r, i, obsIssue[i], progEntry(i, 8'(i), i == lastPc)); end
         end
         checks++; if (maxCredit > QUEUE_SIZE) begin failures++; $display("[TB] FAIL rand%0d_credit: got %0d expected <= %0d", r, maxCredit, QUEUE_SIZE); end
         checks++; if (fetchAfterLast != 0) begin failures++; $display("[TB] FAIL rand%0d_fetch_after_last: got %0d expected 0", r, fetchAfterLast); end
         checks++; if (bus.id_error !== 1'b0) begin failures++; $display("[TB] FAIL rand%0d_id_error: got %b expected 0", r, bus.id_error); end
      end
   endtask

   // Scenario sequence and final summary
   initial begin
      driveIdle();
      clearModel();
      setRates(0, 0, 0, 1);
      lastPc = 200;
      test_reset();
      test_full_program();
      test_backpressure();
      test_fetch_stall();
      test_id_error();
      test_early_last();
      test_reset_midway();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   // Guard against a hung simulation
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no completion expected finish before 2 ms");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
